// File: rtl/oam_responder.sv
// OAM target: 160-byte object attribute memory shared by the DMA write stream,
// CPU MMIO and the PPU sprite-entry fetcher, with fixed-priority arbitration
// (DMA > PPU > CPU) and CPU bus lockout.
module oam_responder #(
  parameter int          OAM_BYTES = 160,
  parameter logic [7:0]  OAM_PAGE  = 8'hFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_wr,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_dout,
  input  logic        dma_occupy_oambus,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        ppu_lock,
  input  logic        ppu_req,
  input  logic [5:0]  ppu_idx,
  output logic        ppu_busy,
  output logic        ppu_ack,
  output logic [7:0]  ppu_y,
  output logic [7:0]  ppu_x,
  output logic [7:0]  ppu_tile,
  output logic [7:0]  ppu_attr
);

  localparam logic [8:0] LP_BYTES   = 9'(OAM_BYTES);
  localparam logic [6:0] LP_ENTRIES = 7'(OAM_BYTES / 4);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  logic [7:0] r_mem [OAM_BYTES];

  state_t     r_state, w_state_nx;
  logic [5:0] r_idx, w_idx_nx;
  logic [1:0] r_k, w_k_nx;
  logic       r_ack, w_ack_nx;
  logic       w_ppu_rd;
  logic [7:0] r_cpu_dout;
  logic [7:0] r_y, r_x, r_tile, r_attr;

  logic       w_dma_hit;
  logic       w_cpu_sel, w_cpu_block, w_cpu_in_range, w_cpu_we, w_cpu_re;
  logic [7:0] w_rd_addr, w_rd_data, w_ppu_byte;
  logic       w_idx_ok;

  assign w_dma_hit = dma_wr && (dma_a[15:8] == OAM_PAGE) && ({1'b0, dma_a[7:0]} < LP_BYTES);

  assign w_cpu_sel      = (cpu_a[15:8] == OAM_PAGE);
  assign w_cpu_block    = dma_occupy_oambus || ppu_lock || w_dma_hit || (r_state == S_FETCH);
  assign w_cpu_in_range = ({1'b0, cpu_a[7:0]} < LP_BYTES);
  assign w_cpu_we       = cpu_wr && w_cpu_sel && !w_cpu_block && w_cpu_in_range;
  // A simultaneous write takes precedence, so the read path stays quiet.
  assign w_cpu_re       = cpu_rd && !cpu_wr && w_cpu_sel;

  // {idx,k} is exactly 4*idx+k; the single read port goes to the PPU while fetching.
  assign w_rd_addr  = (r_state == S_FETCH) ? {r_idx, r_k} : cpu_a[7:0];
  assign w_rd_data  = r_mem[w_rd_addr];
  assign w_idx_ok   = ({1'b0, r_idx} < LP_ENTRIES);
  assign w_ppu_byte = w_idx_ok ? w_rd_data : 8'hFF;

  // Array write port: DMA always wins, CPU writes only when not locked out.
  always_ff @(posedge clk) begin
    if (w_dma_hit)
      r_mem[dma_a[7:0]] <= dma_dout;
    else if (w_cpu_we)
      r_mem[cpu_a[7:0]] <= cpu_din;
  end

  // CPU read data register; holds when no read strobe is accepted.
  always_ff @(posedge clk) begin
    if (rst)
      r_cpu_dout <= 8'hFF;
    else if (w_cpu_re) begin
      if (w_cpu_block)
        r_cpu_dout <= 8'hFF;
      else if (!w_cpu_in_range)
        r_cpu_dout <= 8'h00;
      else
        r_cpu_dout <= w_rd_data;
    end
  end

  // Fetch FSM next-state: a DMA hit stalls the byte counter for a cycle.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_k_nx     = r_k;
    w_ack_nx   = 1'b0;
    w_ppu_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ppu_req) begin
          w_idx_nx   = ppu_idx;
          w_k_nx     = '0;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!w_dma_hit) begin
          w_ppu_rd = 1'b1;
          w_k_nx   = r_k + 2'd1;
          if (r_k == 2'd3) begin
            w_state_nx = S_IDLE;
            w_ack_nx   = 1'b1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_k     <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_k     <= w_k_nx;
      r_ack   <= w_ack_nx;
    end
  end

  // Sprite-entry output bytes, one per fetch cycle, held until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y    <= '0;
      r_x    <= '0;
      r_tile <= '0;
      r_attr <= '0;
    end else if (w_ppu_rd) begin
      case (r_k)
        2'd0: r_y    <= w_ppu_byte;
        2'd1: r_x    <= w_ppu_byte;
        2'd2: r_tile <= w_ppu_byte;
        default: r_attr <= w_ppu_byte;
      endcase
    end
  end

  assign cpu_dout = r_cpu_dout;
  assign ppu_busy = (r_state == S_FETCH);
  assign ppu_ack  = r_ack;
  assign ppu_y    = r_y;
  assign ppu_x    = r_x;
  assign ppu_tile = r_tile;
  assign ppu_attr = r_attr;

endmodule

// File: tb/tb_oam_responder.sv
// Scoreboard bench for oam_responder: stimulus pushes expected CPU read data
// and expected PPU entries (with ack cycle); a monitor pops and compares.
module tb_oam_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_wr;
  logic [15:0] dma_a;
  logic [7:0]  dma_dout;
  logic        dma_occupy_oambus;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        ppu_lock, ppu_req;
  logic [5:0]  ppu_idx;
  logic        ppu_busy, ppu_ack;
  logic [7:0]  ppu_y, ppu_x, ppu_tile, ppu_attr;

  always #5 clk = ~clk;

  oam_responder #(.OAM_BYTES(160), .OAM_PAGE(8'hFE)) dut (
    .clk(clk), .rst(rst),
    .dma_wr(dma_wr), .dma_a(dma_a), .dma_dout(dma_dout),
    .dma_occupy_oambus(dma_occupy_oambus),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout),
    .ppu_lock(ppu_lock), .ppu_req(ppu_req), .ppu_idx(ppu_idx),
    .ppu_busy(ppu_busy), .ppu_ack(ppu_ack),
    .ppu_y(ppu_y), .ppu_x(ppu_x), .ppu_tile(ppu_tile), .ppu_attr(ppu_attr)
  );

  typedef struct {
    logic [31:0] bytes;
    int unsigned cyc;
  } ppu_exp_t;

  logic [7:0]  cpu_q [$];
  ppu_exp_t    ppu_q [$];
  int          checks = 0;
  int          errors = 0;
  int          ack_count = 0;
  int unsigned cyc = 0;
  logic        rd_seen = 1'b0;
  logic [7:0]  mon_e;
  ppu_exp_t    mon_p;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_seen <= cpu_rd && !cpu_wr && (cpu_a[15:8] == 8'hFE) && !rst;
  end

  // Monitor: compare CPU read data the cycle after each read strobe, and the
  // PPU entry on every ack.
  always @(negedge clk) begin
    if (rd_seen) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_read_unexpected: got %02h, no read expected", cpu_dout);
      end else begin
        mon_e = cpu_q.pop_front();
        if (cpu_dout !== mon_e) begin
          errors++;
          $display("FAIL cpu_read: got %02h expected %02h", cpu_dout, mon_e);
        end
      end
    end
    if (ppu_ack) begin
      ack_count++;
      checks++;
      if (ppu_q.size() == 0) begin
        errors++;
        $display("FAIL ppu_ack_unexpected at cycle %0d", cyc);
      end else begin
        mon_p = ppu_q.pop_front();
        if ({ppu_y, ppu_x, ppu_tile, ppu_attr} !== mon_p.bytes || cyc != mon_p.cyc) begin
          errors++;
          $display("FAIL ppu_entry: got %08h at cycle %0d expected %08h at cycle %0d",
                   {ppu_y, ppu_x, ppu_tile, ppu_attr}, cyc, mon_p.bytes, mon_p.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_a = a; cpu_din = d;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
    cpu_q.push_back(exp);
    cpu_rd = 1'b1; cpu_a = a;
    tick();
    cpu_rd = 1'b0;
    tick();
  endtask

  // Called at posedge+1; the req is sampled at the next edge, ack follows 5+stalls cycles later.
  task automatic ppu_request(input logic [5:0] idx, input logic [31:0] bytes,
                             input int stalls, input bit push);
    ppu_exp_t p;
    if (push) begin
      p.bytes = bytes;
      p.cyc   = cyc + 5 + stalls;
      ppu_q.push_back(p);
    end
    ppu_req = 1'b1; ppu_idx = idx;
    tick();
    ppu_req = 1'b0;
  endtask

  task automatic wait_ack(output int busy_n);
    bit ok;
    busy_n = 0;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (ppu_ack) ok = 1'b1;
      else if (ppu_busy) busy_n++;
    end
    tick();
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ppu_ack_timeout: got no ack within 30 cycles, expected one");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_n;
    logic [7:0] b;
    rst = 1'b1; dma_wr = 1'b0; dma_a = '0; dma_dout = '0; dma_occupy_oambus = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_din = '0;
    ppu_lock = 1'b0; ppu_req = 1'b0; ppu_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cpu_dout", 32'(cpu_dout), 32'hFF);
    chk("reset_busy", 32'(ppu_busy), 0);
    chk("reset_ack", 32'(ppu_ack), 0);
    chk("reset_entry", {ppu_y, ppu_x, ppu_tile, ppu_attr}, 0);
    rst = 1'b0;
    tick();

    // DMA fill, each write held two cycles
    dma_occupy_oambus = 1'b1;
    for (int i = 0; i < 160; i++) begin
      b = 8'(i);
      dma_wr = 1'b1; dma_a = 16'hFE00 + 16'(i); dma_dout = b ^ 8'h5A;
      tick();
      tick();
    end
    dma_a = 16'hFEA0; dma_dout = 8'h77; tick();   // out of range, ignored
    dma_a = 16'hFD05; dma_dout = 8'h77; tick();   // wrong page, ignored
    dma_wr = 1'b0; dma_occupy_oambus = 1'b0;
    tick();
    cpu_read(16'hFE00, 8'h5A);
    cpu_read(16'hFE4F, 8'h15);
    cpu_read(16'hFE9F, 8'hC5);
    cpu_read(16'hFE05, 8'h5F);
    cpu_read(16'hFEA0, 8'h00);

    // CPU lockout
    dma_occupy_oambus = 1'b1;
    cpu_write(16'hFE10, 8'h33);
    cpu_read(16'hFE10, 8'hFF);
    dma_occupy_oambus = 1'b0;
    tick();
    cpu_read(16'hFE10, 8'h4A);
    cpu_read(16'hFEA5, 8'h00);
    ppu_lock = 1'b1;
    cpu_read(16'hFE20, 8'hFF);
    ppu_lock = 1'b0;
    cpu_write(16'hFD10, 8'h99);
    cpu_read(16'hFE10, 8'h4A);
    cpu_write(16'hFE11, 8'hC3);
    cpu_read(16'hFE11, 8'hC3);

    // PPU fetch
    cpu_write(16'hFE08, 8'd10);
    cpu_write(16'hFE09, 8'd20);
    cpu_write(16'hFE0A, 8'd30);
    cpu_write(16'hFE0B, 8'd40);
    ppu_request(6'd2, {8'd10, 8'd20, 8'd30, 8'd40}, 0, 1'b1);
    wait_ack(busy_n);
    chk("ppu_busy_cycles", 32'(busy_n), 4);

    // DMA preemption: two hit cycles after the first byte read
    cpu_write(16'hFE0C, 8'h11);
    cpu_write(16'hFE0D, 8'h22);
    cpu_write(16'hFE0E, 8'h33);
    cpu_write(16'hFE0F, 8'h44);
    ppu_request(6'd3, 32'h11223344, 2, 1'b1);
    tick();
    dma_wr = 1'b1; dma_a = 16'hFE50; dma_dout = 8'hA7;
    tick();
    tick();
    dma_wr = 1'b0;
    wait_ack(busy_n);
    cpu_read(16'hFE50, 8'hA7);

    // Bad index
    ppu_request(6'd45, 32'hFFFFFFFF, 0, 1'b1);
    wait_ack(busy_n);

    // Request while busy is ignored
    ppu_request(6'd2, {8'd10, 8'd20, 8'd30, 8'd40}, 0, 1'b1);
    tick();
    ppu_req = 1'b1; ppu_idx = 6'd3;
    tick();
    ppu_req = 1'b0;
    wait_ack(busy_n);
    repeat (8) tick();
    chk("ack_count_after_busy_req", 32'(ack_count), 4);

    // Reset mid-fetch at k=2
    ppu_request(6'd3, 32'h0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(ppu_busy), 0);
    chk("rst_mid_ack", 32'(ppu_ack), 0);
    chk("rst_mid_entry", {ppu_y, ppu_x, ppu_tile, ppu_attr}, 0);
    chk("rst_mid_cpu_dout", 32'(cpu_dout), 32'hFF);
    repeat (8) tick();
    chk("ack_count_after_reset", 32'(ack_count), 4);
    cpu_read(16'hFE08, 8'd10);
    cpu_read(16'hFE0F, 8'h44);

    chk("cpu_queue_drained", 32'(cpu_q.size()), 0);
    chk("ppu_queue_drained", 32'(ppu_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_responder.md
Name: oam_responder

Overview:
- Target-side block for OAM DMA. Owns the 160-byte object attribute memory at FE00-FE9F.
- Services three masters on one single-ported array:
  - DMA write stream, issued by the DMA initiator.
  - CPU MMIO reads and writes.
  - PPU 4-byte sprite-entry fetches.
- Enforces fixed-priority arbitration and OAM bus lockout, so that OAM contents and CPU/PPU read data are deterministic at cycle level.

Parameters:
- OAM_BYTES, 160, number of bytes stored; valid offsets are 0..OAM_BYTES-1.
- OAM_PAGE, 8'hFE, high address byte that selects OAM.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- dma_wr  in  1  DMA write strobe; may stay high for consecutive cycles on the same address/data
- dma_a  in  16  DMA address
- dma_dout  in  8  DMA write data
- dma_occupy_oambus  in  1  DMA owns the OAM bus; CPU lockout
- cpu_rd  in  1  CPU read strobe, single cycle
- cpu_wr  in  1  CPU write strobe, single cycle
- cpu_a  in  16  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data, registered
- ppu_lock  in  1  PPU in mode 2/3; CPU lockout
- ppu_req  in  1  sprite fetch request pulse
- ppu_idx  in  6  sprite index, 0..39
- ppu_busy  out  1  fetch in progress
- ppu_ack  out  1  one-cycle pulse: the four ppu_* bytes are valid
- ppu_y, ppu_x, ppu_tile, ppu_attr  out  8 each  fetched entry, bytes 4*idx+0..3

Behaviour:
- Reset values:
  - cpu_dout=8'hFF, ppu_busy=0, ppu_ack=0, ppu_y/x/tile/attr=8'h00, FSM=IDLE, byte counter=0.
  - OAM array contents are NOT cleared.
- DMA hit: dma_wr && dma_a[15:8]==OAM_PAGE && dma_a[7:0]<OAM_BYTES. On hit, the array byte dma_a[7:0] takes dma_dout at the edge.
  - Repeated dma_wr on the same address is idempotent.
  - dma_wr outside the hit range is ignored.
- Arbitration, one array access per cycle:
  - Priority: DMA hit > PPU fetch read > CPU.
  - A DMA hit is never dropped and never delayed.
- CPU access rules. Evaluate in order; cpu_dout updates at the edge after the strobe and holds otherwise.
  - Blocked if dma_occupy_oambus, ppu_lock, a DMA hit in the same cycle, or FSM in FETCH. Blocked reads give cpu_dout=8'hFF; blocked writes are dropped.
  - Address FEA0-FEFF: reads give 8'h00; writes are ignored.
  - Otherwise, reads give the array byte (1-cycle latency) and writes update the array at the edge.
  - cpu_rd and cpu_wr high together: write wins, cpu_dout unchanged.
  - Strobes with cpu_a[15:8]!=OAM_PAGE are ignored entirely.
- PPU fetch FSM, states IDLE and FETCH:
  - IDLE: when ppu_req is high, latch ppu_idx and clear byte counter k=0. Next state FETCH, ppu_busy=1.
  - FETCH, per cycle:
    - With a DMA hit: stall; k holds.
    - Without a DMA hit: read byte 4*idx+k into output register k (0=y, 1=x, 2=tile, 3=attr), then k++.
    - After the k=3 read: state goes to IDLE, ppu_busy=0, ppu_ack=1 for exactly one cycle.
  - Unstalled latency: req sampled at edge E0; reads at E1..E4; ack high in the cycle after E4.
  - Each DMA stall cycle adds one cycle of latency.
  - ppu_req while busy is ignored; a new req is accepted in the same cycle ack is high.
  - ppu_idx>39: no array reads; all four bytes are 8'hFF, with the same latency and stall rules.
  - Output bytes hold their values until the next fetch overwrites them.
- Reset mid-fetch: abort; no ack; all outputs return to reset values.
- Array addressing uses 8-bit offsets; no wrap beyond OAM_BYTES-1.

Test Plan:
- DMA fill: drive 160 dma_wr pulses, FE00+i with data i^8'h5A, each held 2 cycles. Then release occupy, CPU-read FE00, FE4F, FE9F -> 8'h5A, 8'h15, 8'hC5, each one cycle after the strobe.
- CPU lockout: dma_occupy_oambus=1, CPU write FE10=8'h33 then read FE10 -> cpu_dout=8'hFF. After occupy drops, read FE10 -> old value. Read FEA5 while unlocked -> 8'h00.
- PPU fetch: OAM bytes 8..11 = 10,20,30,40. Pulse ppu_req with idx=2 -> ack exactly 5 cycles after the req cycle, y/x/tile/attr = 10/20/30/40, busy high for 4 cycles.
- DMA preemption: during a fetch, inject 2 DMA hit cycles -> ack delayed by 2 cycles, fetched bytes correct, DMA data present in the array.
- Bad index / busy req: req idx=45 -> all four bytes FF, ack at the normal latency. A second req while busy -> ignored, only one ack.
- Reset mid-fetch: assert rst at k=2 -> no ack, outputs 0, cpu_dout FF. A subsequent CPU read returns the pre-reset OAM contents.
